// File: rtl/led_control_multi.sv
// rtl/led_control_multi.sv - multi-channel LED flasher with shared tick prescaler
module led_control_multi #(
    parameter int CLOCK_SPEED   = 25000000,
    parameter int TICK_HZ       = 1000,
    parameter int NUM_LEDS      = 4,
    parameter int SLOW_TICKS    = 500,
    parameter int FAST_TICKS    = 100,
    parameter int STRETCH_TICKS = 50,
    parameter int GAP_TICKS     = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3*NUM_LEDS-1:0]   mode,
    input  logic [NUM_LEDS-1:0]     trigger,
    input  logic [4*NUM_LEDS-1:0]   code,
    output logic [NUM_LEDS-1:0]     led,
    output logic                    tick
);

    localparam int DIV_RAW = CLOCK_SPEED / TICK_HZ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [15:0] SLOW_LAST = 16'(SLOW_TICKS - 1);
    localparam logic [15:0] FAST_LAST = 16'(FAST_TICKS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);
    localparam logic [15:0] STRETCH   = 16'(STRETCH_TICKS);

    localparam logic [2:0] M_OFF  = 3'd0;
    localparam logic [2:0] M_ON   = 3'd1;
    localparam logic [2:0] M_SLOW = 3'd2;
    localparam logic [2:0] M_FAST = 3'd3;
    localparam logic [2:0] M_VARY = 3'd4;
    localparam logic [2:0] M_ACT  = 3'd5;
    localparam logic [2:0] M_CODE = 3'd6;

    typedef enum logic [1:0] {B_LOAD, B_ON, B_OFF, B_GAP} blink_state_t;

    // Tick counts live in 16-bit counters, so larger settings cannot be built.
    if (SLOW_TICKS > 65535 || FAST_TICKS > 65535 || STRETCH_TICKS > 65535 ||
        GAP_TICKS > 65535) begin : g_ticks_range
        $error("led_control_multi: *_TICKS must be <= 65535");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_num_range
        $error("led_control_multi: NUM_LEDS must be 1..16");
    end

    logic [PW-1:0] presc;
    logic          tick_r;

    // Shared prescaler: one-clock tick strobe every DIV clocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            tick_r <= 1'b0;
        end else if (presc == PRESC_LAST) begin
            presc  <= '0;
            tick_r <= 1'b1;
        end else begin
            presc  <= presc + PW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        logic [2:0]   mode_i;
        logic [3:0]   code_i;
        logic         trig_i;
        logic [2:0]   prev_mode;
        logic [15:0]  cnt;
        logic [15:0]  half_last;
        logic [1:0]   phase;
        logic [3:0]   n_code;
        logic [3:0]   pulses;
        blink_state_t bstate;
        logic         led_r;

        assign mode_i = mode[3*i +: 3];
        assign code_i = code[4*i +: 4];
        assign trig_i = trigger[i];

        // Half-period for the flashing modes; vary uses slow for phases 0-1, fast for 2-3.
        always_comb begin
            half_last = SLOW_LAST;
            if (mode_i == M_FAST) begin
                half_last = FAST_LAST;
            end else if (mode_i == M_VARY && phase[1]) begin
                half_last = FAST_LAST;
            end
        end

        // Channel engine: a mode change reinitialises and beats any same-cycle tick.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                prev_mode <= M_OFF;
                cnt       <= '0;
                phase     <= '0;
                n_code    <= '0;
                pulses    <= '0;
                bstate    <= B_LOAD;
                led_r     <= 1'b0;
            end else if (mode_i != prev_mode) begin
                prev_mode <= mode_i;
                cnt       <= '0;
                phase     <= '0;
                pulses    <= '0;
                bstate    <= B_LOAD;
                led_r     <= (mode_i == M_ON) || (mode_i == M_SLOW) ||
                             (mode_i == M_FAST) || (mode_i == M_VARY);
            end else begin
                case (mode_i)
                    M_ON: led_r <= 1'b1;
                    M_SLOW, M_FAST, M_VARY: begin
                        if (tick_r) begin
                            if (cnt == half_last) begin
                                cnt   <= '0;
                                led_r <= ~led_r;
                                phase <= phase + 2'd1;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    M_ACT: begin
                        if (trig_i) begin
                            led_r <= 1'b1;
                            cnt   <= STRETCH;
                        end else if (tick_r && cnt != 16'd0) begin
                            cnt <= cnt - 16'd1;
                            if (cnt == 16'd1) begin
                                led_r <= 1'b0;
                            end
                        end
                    end
                    M_CODE: begin
                        case (bstate)
                            B_LOAD: begin
                                n_code <= code_i;
                                pulses <= '0;
                                cnt    <= '0;
                                if (code_i == 4'd0) begin
                                    bstate <= B_GAP;
                                    led_r  <= 1'b0;
                                end else begin
                                    bstate <= B_ON;
                                    led_r  <= 1'b1;
                                end
                            end
                            B_ON: begin
                                if (tick_r) begin
                                    if (cnt == FAST_LAST) begin
                                        cnt    <= '0;
                                        led_r  <= 1'b0;
                                        pulses <= pulses + 4'd1;
                                        bstate <= B_OFF;
                                    end else begin
                                        cnt <= cnt + 16'd1;
                                    end
                                end
                            end
                            B_OFF: begin
                                if (tick_r) begin
                                    if (cnt == FAST_LAST) begin
                                        cnt <= '0;
                                        if (pulses < n_code) begin
                                            bstate <= B_ON;
                                            led_r  <= 1'b1;
                                        end else begin
                                            bstate <= B_GAP;
                                        end
                                    end else begin
                                        cnt <= cnt + 16'd1;
                                    end
                                end
                            end
                            B_GAP: begin
                                led_r <= 1'b0;
                                if (tick_r) begin
                                    if (cnt == GAP_LAST) begin
                                        cnt    <= '0;
                                        bstate <= B_LOAD;
                                    end else begin
                                        cnt <= cnt + 16'd1;
                                    end
                                end
                            end
                            default: bstate <= B_LOAD;
                        endcase
                    end
                    default: led_r <= 1'b0;
                endcase
            end
        end

        assign led[i] = led_r;
    end

endmodule

// File: tb/tb_led_control_multi.sv
// tb/tb_led_control_multi.sv - scoreboard bench for led_control_multi
module tb_led_control_multi;

    localparam int CLOCK_SPEED   = 1000;
    localparam int TICK_HZ       = 100;
    localparam int NUM_LEDS      = 4;
    localparam int SLOW_TICKS    = 5;
    localparam int FAST_TICKS    = 2;
    localparam int STRETCH_TICKS = 3;
    localparam int GAP_TICKS     = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mode = '0;
    logic [3:0]  trigger = '0;
    logic [15:0] code = '0;
    logic [3:0]  led;
    logic        tick;

    int checks = 0;
    int failures = 0;

    // Expected runs per signal (0..3 = led channel, 4 = tick), encoded level*1000 + length.
    int exp_q[5][$];

    led_control_multi #(
        .CLOCK_SPEED  (CLOCK_SPEED),
        .TICK_HZ      (TICK_HZ),
        .NUM_LEDS     (NUM_LEDS),
        .SLOW_TICKS   (SLOW_TICKS),
        .FAST_TICKS   (FAST_TICKS),
        .STRETCH_TICKS(STRETCH_TICKS),
        .GAP_TICKS    (GAP_TICKS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .mode   (mode),
        .trigger(trigger),
        .code   (code),
        .led    (led),
        .tick   (tick)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sig(input int sel);
        if (sel < 4) return int'(led[sel]);
        return int'(tick);
    endfunction

    task automatic push_run(input int sel, input int lvl, input int len);
        exp_q[sel].push_back(lvl * 1000 + len);
    endtask

    task automatic set_mode(input int ch, input logic [2:0] m);
        mode[3*ch +: 3] = m;
    endtask

    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                @(negedge clock);
                if (tick === 1'b1) found = 1'b1;
            end
        end
        if (!found) check_eq("tick_wait", 0, 1);
    endtask

    task automatic pop_check(input int sel, input string tag, input int idx, input int obs);
        if (exp_q[sel].size() > 0) begin
            check_eq($sformatf("%s_%0d", tag, idx), obs, exp_q[sel].pop_front());
        end else begin
            check_eq($sformatf("%s_extra%0d", tag, idx), obs, -1);
        end
    endtask

    // Samples one signal for budget negedges and compares each run against the queue.
    task automatic measure(input int sel, input int budget, input string tag);
        int cur;
        int len;
        int idx;
        idx = 0;
        @(negedge clock);
        cur = sig(sel);
        len = 1;
        for (int n = 1; n < budget; n++) begin
            @(negedge clock);
            if (sig(sel) == cur) begin
                len++;
            end else begin
                pop_check(sel, tag, idx, cur * 1000 + len);
                idx++;
                cur = sig(sel);
                len = 1;
            end
        end
        pop_check(sel, tag, idx, cur * 1000 + len);
        while (exp_q[sel].size() > 0) begin
            check_eq($sformatf("%s_missing", tag), -1, exp_q[sel].pop_front());
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_eq("rst_led", int'(led), 0);
        check_eq("rst_tick", int'(tick), 0);
        reset = 1'b0;

        for (int k = 0; k < 3; k++) begin
            push_run(4, 0, 9);
            push_run(4, 1, 1);
        end
        measure(4, 30, "t1_tick");

        set_mode(1, 3'd1);
        wait_tick();
        repeat (3) @(negedge clock);
        check_eq("t1_on", sig(1), 1);
        reset = 1'b1;
        #1;
        check_eq("t1_rst_led", int'(led), 0);
        check_eq("t1_rst_tick", int'(tick), 0);
        mode = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_run(4, 0, 9);
            push_run(4, 1, 1);
        end
        measure(4, 20, "t1_release");

        wait_tick();
        set_mode(0, 3'd2);
        set_mode(1, 3'd3);
        push_run(0, 1, 50); push_run(0, 0, 50); push_run(0, 1, 50);
        for (int k = 0; k < 2; k++) begin
            push_run(1, 1, 20);
            push_run(1, 0, 20);
        end
        push_run(1, 1, 20);
        fork
            measure(0, 150, "t2_slow");
            measure(1, 100, "t2_fast");
        join

        wait_tick();
        set_mode(2, 3'd4);
        push_run(2, 1, 50); push_run(2, 0, 50);
        push_run(2, 1, 20); push_run(2, 0, 20);
        push_run(2, 1, 50); push_run(2, 0, 50);
        measure(2, 240, "t3_vary");

        set_mode(3, 3'd5);
        wait_tick();
        trigger[3] = 1'b1;
        push_run(3, 1, 30); push_run(3, 0, 10);
        fork
            measure(3, 40, "t4_pulse");
            begin @(negedge clock); trigger[3] = 1'b0; end
        join

        wait_tick();
        trigger[3] = 1'b1;
        push_run(3, 1, 50); push_run(3, 0, 10);
        fork
            measure(3, 60, "t4_retrig");
            begin
                @(negedge clock); trigger[3] = 1'b0;
                repeat (19) @(negedge clock); trigger[3] = 1'b1;
                @(negedge clock); trigger[3] = 1'b0;
            end
        join

        wait_tick();
        trigger[3] = 1'b1;
        push_run(3, 1, 80); push_run(3, 0, 10);
        fork
            measure(3, 90, "t4_held");
            begin repeat (60) @(negedge clock); trigger[3] = 1'b0; end
        join

        wait_tick();
        code[3:0] = 4'd3;
        set_mode(0, 3'd6);
        push_run(0, 0, 1);
        push_run(0, 1, 19); push_run(0, 0, 20);
        push_run(0, 1, 20); push_run(0, 0, 20);
        push_run(0, 1, 20); push_run(0, 0, 61);
        push_run(0, 1, 19); push_run(0, 0, 61);
        push_run(0, 1, 19);
        fork
            measure(0, 260, "t5_code");
            begin repeat (40) @(negedge clock); code[3:0] = 4'd1; end
        join

        code[3:0] = 4'd0;
        set_mode(0, 3'd0);
        @(negedge clock);
        wait_tick();
        set_mode(0, 3'd6);
        push_run(0, 0, 200);
        measure(0, 200, "t5_zero");

        wait_tick();
        code[7:4] = 4'd3;
        set_mode(1, 3'd6);
        for (int k = 0; k < 5; k++) wait_tick();
        check_eq("t6_inpulse", sig(1), 1);
        set_mode(1, 3'd2);
        push_run(1, 1, 50); push_run(1, 0, 50); push_run(1, 1, 10);
        measure(1, 110, "t6_switch");

        set_mode(1, 3'd7);
        push_run(1, 0, 20);
        measure(1, 20, "t6_mode7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
